// File: rtl/bin2bcd_seq_if.sv
// Converter request/result bundle: start + binary value in, busy/done + BCD result out.
// Latency: pure wiring, no registers.
// Backpressure: none; requester must observe busy, starts while busy are dropped by the slave.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [15:0]           disp;
    logic                  ovf;

    modport master (
        output start, bin,
        input  busy, done, bcd, disp, ovf
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, disp, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle.
// Latency: start accepted at edge t -> busy t+1..t+WIDTH, done pulse + new result in t+WIDTH+1.
// Backpressure: start only accepted when busy=0 (IDLE or DONE); starts while busy are dropped.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic          clk,
    input  logic          RST,
    bin2bcd_seq_if.slave  io
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [WIDTH-1:0]     shift_q;
    logic [BCD_W-1:0]     scratch_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [BCD_W-1:0]     scratch_adj;
    logic [BCD_W+WIDTH-1:0] shifted;
    logic [BCD_W-1:0]     scratch_nxt;
    logic [WIDTH-1:0]     shift_nxt;
    logic                 ovf_nxt;

    logic [BCD_W-1:0]     bcd_q;
    logic [15:0]          disp_q;
    logic                 ovf_q;
    logic                 done_q;

    logic                 accept;
    logic                 last_iter;

    // A new request is taken whenever no shift is in progress, including the DONE cycle.
    assign accept    = (state != SHIFT) && io.start;
    assign last_iter = (state == SHIFT) && (cnt_q == CNT_W'(1));

    // Add-3 correction: each scratch digit >= 5 gets +3 so the following shift carries into the next digit.
    always_comb begin
        scratch_adj = scratch_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5) begin
                scratch_adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // One-bit left shift of {scratch, shiftreg}; the shift register MSB enters scratch bit 0.
    assign shifted     = {scratch_adj, shift_q} << 1;
    assign scratch_nxt = shifted[BCD_W+WIDTH-1 -: BCD_W];
    assign shift_nxt   = shifted[WIDTH-1:0];

    // Overflow flag covers the digits beyond the four that reach the display.
    generate
        if (DIGITS > 4) begin : g_ovf
            assign ovf_nxt = |scratch_nxt[BCD_W-1:16];
        end else begin : g_no_ovf
            assign ovf_nxt = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> SHIFT on start, SHIFT for WIDTH cycles, single DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (io.start) state_nxt = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = io.start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in SHIFT, publish the final scratch on the edge entering DONE
    // so the result and the done pulse appear together in the DONE cycle.
    always_ff @(posedge clk) begin
        if (RST) begin
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                shift_q   <= io.bin;
                scratch_q <= '0;
                cnt_q     <= CNT_W'(WIDTH);
            end else if (state == SHIFT) begin
                shift_q   <= shift_nxt;
                scratch_q <= scratch_nxt;
                cnt_q     <= cnt_q - CNT_W'(1);
                if (last_iter) begin
                    bcd_q  <= scratch_nxt;
                    disp_q <= scratch_nxt[15:0];
                    ovf_q  <= ovf_nxt;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign io.busy = (state == SHIFT);
    assign io.done = done_q;
    assign io.bcd  = bcd_q;
    assign io.disp = disp_q;
    assign io.ovf  = ovf_q;

endmodule
